// File: rtl/vtiming_gen_prog_if.sv
// Configuration bus for vtiming_gen_prog: the shadow-register write port
// plus its pending/error status.
interface vtiming_gen_prog_if #(
    parameter int CNT_W = 11
);
    logic             cfg_wr;
    logic [CNT_W-1:0] cfg_active;
    logic [CNT_W-1:0] cfg_fp;
    logic [CNT_W-1:0] cfg_sync;
    logic [CNT_W-1:0] cfg_bp;
    logic             cfg_vpol;
    logic             cfg_pending;
    logic             cfg_err;

    modport master (
        output cfg_wr, cfg_active, cfg_fp, cfg_sync, cfg_bp, cfg_vpol,
        input  cfg_pending, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_active, cfg_fp, cfg_sync, cfg_bp, cfg_vpol,
        output cfg_pending, cfg_err
    );
endinterface

// File: rtl/vtiming_gen_prog.sv
// Programmable vertical timing generator.
// Line counter advanced by eol, VSYNC/visible decode, frame-boundary pulses,
// CDC toggles and a frame counter. Timing is written into a shadow set and
// only copied to the active set at the frame boundary, so a frame is never
// torn. Optional raster compare enabled by defining VTIMING_RASTER_CMP_EN.
module vtiming_gen_prog #(
    parameter int CNT_W       = 11,
    parameter int DEF_ACTIVE  = 480,
    parameter int DEF_FP      = 10,
    parameter int DEF_SYNC    = 2,
    parameter int DEF_BP      = 33,
    parameter int DEF_VPOL    = 0,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   pix_clk,
    input  logic                   rst,
    vtiming_gen_prog_if.slave      cfg_bus,
    input  logic                   eol,
    input  logic [CNT_W-1:0]       cmp_line,
    output logic [CNT_W-1:0]       v_cnt,
    output logic                   vsync,
    output logic                   v_visible,
    output logic                   eof,
    output logic                   vblank_start,
    output logic                   vblank_toggle,
    output logic                   eof_toggle,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   line_match
);
    // Two extra bits so sums of four CNT_W fields never overflow.
    localparam int TW = CNT_W + 2;

    typedef struct packed {
        logic [CNT_W-1:0] active;
        logic [CNT_W-1:0] fp;
        logic [CNT_W-1:0] sync;
        logic [CNT_W-1:0] bp;
        logic             vpol;
    } vt_cfg_t;

    localparam vt_cfg_t DEF_CFG = '{
        active: CNT_W'(DEF_ACTIVE),
        fp:     CNT_W'(DEF_FP),
        sync:   CNT_W'(DEF_SYNC),
        bp:     CNT_W'(DEF_BP),
        vpol:   1'(DEF_VPOL)
    };

    function automatic logic [TW-1:0] total_of(input vt_cfg_t c);
        return TW'(c.active) + TW'(c.fp) + TW'(c.sync) + TW'(c.bp);
    endfunction

    vt_cfg_t       act_q, shd_q, req;
    logic          pending_q, err_q;
    logic [TW-1:0] total, sync_lo, sync_hi, vcnt_w;
    logic          insync, last_line, last_vis, req_ok, cfg_acc, apply;

    assign req = '{
        active: cfg_bus.cfg_active,
        fp:     cfg_bus.cfg_fp,
        sync:   cfg_bus.cfg_sync,
        bp:     cfg_bus.cfg_bp,
        vpol:   cfg_bus.cfg_vpol
    };

    assign total   = total_of(act_q);
    assign vcnt_w  = TW'(v_cnt);
    assign sync_lo = TW'(act_q.active) + TW'(act_q.fp);
    assign sync_hi = sync_lo + TW'(act_q.sync);

    // Active set always has active >= 1 and total >= 3, so the -1 terms
    // below never underflow.
    assign last_line = eol && (vcnt_w == total - TW'(1));
    assign last_vis  = eol && (v_cnt == act_q.active - CNT_W'(1));

    // fp = 0 is legal; a full 2^CNT_W-line frame is the largest accepted.
    assign req_ok  = (|req.active) && (|req.sync) && (|req.bp) &&
                     (total_of(req) <= (TW'(1) << CNT_W));
    assign cfg_acc = cfg_bus.cfg_wr && req_ok;
    assign apply   = last_line && pending_q;

    assign insync    = (vcnt_w >= sync_lo) && (vcnt_w < sync_hi);
    assign vsync     = act_q.vpol ? insync : ~insync;
    assign v_visible = (v_cnt < act_q.active);

    assign cfg_bus.cfg_pending = pending_q;
    assign cfg_bus.cfg_err     = err_q;

    // Shadow capture, boundary apply and write validation. On a coincident
    // accept+apply the active set takes the old shadow and the new write
    // stays pending for the following frame.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            act_q     <= DEF_CFG;
            shd_q     <= DEF_CFG;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= cfg_bus.cfg_wr && !req_ok;
            if (apply)
                act_q <= shd_q;
            if (cfg_acc)
                shd_q <= req;
            if (cfg_acc)
                pending_q <= 1'b1;
            else if (apply)
                pending_q <= 1'b0;
        end
    end

    // Line counter: wraps on the last line's eol, holds otherwise.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst)
            v_cnt <= '0;
        else if (last_line)
            v_cnt <= '0;
        else if (eol)
            v_cnt <= v_cnt + CNT_W'(1);
    end

    // Frame-boundary pulses, CDC toggles and frame counter.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            eof           <= 1'b0;
            vblank_start  <= 1'b0;
            eof_toggle    <= 1'b0;
            vblank_toggle <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            eof          <= last_line;
            vblank_start <= last_vis;
            if (last_line) begin
                eof_toggle <= ~eof_toggle;
                frame_cnt  <= frame_cnt + FRAME_CNT_W'(1);
            end
            if (last_vis)
                vblank_toggle <= ~vblank_toggle;
        end
    end

`ifdef VTIMING_RASTER_CMP_EN
    // Raster compare against a live cmp_line; v_cnt < total, so an
    // out-of-range cmp_line can never match.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst)
            line_match <= 1'b0;
        else
            line_match <= eol && (v_cnt == cmp_line);
    end
`else
    logic unused_cmp;
    assign unused_cmp = ^cmp_line;
    assign line_match = 1'b0;
`endif
endmodule

// File: tb/tb_vtiming_gen_prog.sv
// Directed bench for vtiming_gen_prog: default frames, reprogramming,
// rejected writes, write coincident with the boundary, mid-frame reset and
// raster compare (when VTIMING_RASTER_CMP_EN is defined).
module tb_vtiming_gen_prog;
    localparam int CNT_W = 11;
`ifdef VTIMING_RASTER_CMP_EN
    localparam int LM_EN = 1;
`else
    localparam int LM_EN = 0;
`endif
    localparam int LM200 = LM_EN ? 200 : -1;

    logic             pix_clk = 1'b0;
    logic             rst;
    logic             eol;
    logic [CNT_W-1:0] cmp_line;
    logic [CNT_W-1:0] v_cnt;
    logic             vsync, v_visible, eof, vblank_start;
    logic             vblank_toggle, eof_toggle, line_match;
    logic [15:0]      frame_cnt;

    vtiming_gen_prog_if #(.CNT_W(CNT_W)) cfg_if ();

    vtiming_gen_prog #(.CNT_W(CNT_W)) dut (
        .pix_clk       (pix_clk),
        .rst           (rst),
        .cfg_bus       (cfg_if),
        .eol           (eol),
        .cmp_line      (cmp_line),
        .v_cnt         (v_cnt),
        .vsync         (vsync),
        .v_visible     (v_visible),
        .eof           (eof),
        .vblank_start  (vblank_start),
        .vblank_toggle (vblank_toggle),
        .eof_toggle    (eof_toggle),
        .frame_cnt     (frame_cnt),
        .line_match    (line_match)
    );

    always #5 pix_clk = ~pix_clk;

    int checks = 0;
    int failures = 0;

    // Per-scan statistics, recorded as the v_cnt value before each eol.
    int s_first, s_last, s_cnt, vbs_line, vbs_cnt, eof_line, eof_cnt, lm_line, lm_cnt;
    logic e1, e0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Runs n lines (eol, then one idle cycle); pol is the asserted vsync level.
    task automatic scan(input int n, input logic pol);
        int vc;
        s_first = -1; s_last = -1; s_cnt = 0;
        vbs_line = -1; vbs_cnt = 0; eof_line = -1; eof_cnt = 0; lm_line = -1; lm_cnt = 0;
        for (int i = 0; i < n; i++) begin
            vc = int'(v_cnt);
            if (vsync == pol) begin
                if (s_first < 0) s_first = vc;
                s_last = vc;
                s_cnt++;
            end
            eol = 1'b1;
            @(negedge pix_clk);
            eol = 1'b0;
            if (eof) begin eof_line = vc; eof_cnt++; end
            if (vblank_start) begin vbs_line = vc; vbs_cnt++; end
            if (line_match) begin lm_line = vc; lm_cnt++; end
            @(negedge pix_clk);
        end
    endtask

    task automatic chk_frame(input string tag, input int eofl, input int vbsl, input int sf,
                             input int sl, input int sc, input int lmc, input int lml);
        chk({tag, "_eof_cnt"}, eof_cnt, 1);
        chk({tag, "_eof_line"}, eof_line, eofl);
        chk({tag, "_vbs_cnt"}, vbs_cnt, 1);
        chk({tag, "_vbs_line"}, vbs_line, vbsl);
        chk({tag, "_sync_first"}, s_first, sf);
        chk({tag, "_sync_last"}, s_last, sl);
        chk({tag, "_sync_cnt"}, s_cnt, sc);
        chk({tag, "_lm_cnt"}, lm_cnt, lmc);
        chk({tag, "_lm_line"}, lm_line, lml);
        chk({tag, "_vcnt_wrap"}, v_cnt, 0);
    endtask

    task automatic cfg_write(input int a, input int f, input int s, input int b, input logic p,
                             output logic err1, output logic err0);
        cfg_if.cfg_active = CNT_W'(a);
        cfg_if.cfg_fp     = CNT_W'(f);
        cfg_if.cfg_sync   = CNT_W'(s);
        cfg_if.cfg_bp     = CNT_W'(b);
        cfg_if.cfg_vpol   = p;
        cfg_if.cfg_wr     = 1'b1;
        @(negedge pix_clk);
        cfg_if.cfg_wr = 1'b0;
        err1 = cfg_if.cfg_err;
        @(negedge pix_clk);
        err0 = cfg_if.cfg_err;
    endtask

    initial begin
        rst = 1'b1; eol = 1'b0; cmp_line = CNT_W'(200);
        cfg_if.cfg_wr = 1'b0; cfg_if.cfg_active = '0; cfg_if.cfg_fp = '0;
        cfg_if.cfg_sync = '0; cfg_if.cfg_bp = '0; cfg_if.cfg_vpol = 1'b0;
        repeat (3) @(negedge pix_clk);
        rst = 1'b0;
        @(negedge pix_clk);

        // Reset state
        chk("rst_vcnt", v_cnt, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_flags", {eof, vblank_start, vblank_toggle, eof_toggle, line_match,
                          cfg_if.cfg_err, cfg_if.cfg_pending}, 0);
        chk("rst_vsync", vsync, 1);
        chk("rst_visible", v_visible, 1);

        // Two default frames
        scan(525, 1'b0);
        chk_frame("def1", 524, 479, 490, 491, 2, LM_EN, LM200);
        chk("def1_frame", frame_cnt, 1);
        chk("def1_toggles", {eof_toggle, vblank_toggle}, 3);
        scan(525, 1'b0);
        chk_frame("def2", 524, 479, 490, 491, 2, LM_EN, LM200);
        chk("def2_frame", frame_cnt, 2);
        chk("def2_toggles", {eof_toggle, vblank_toggle}, 0);

        // Reprogram at v_cnt=100; current frame keeps default timing
        scan(100, 1'b0);
        cfg_write(600, 1, 4, 23, 1'b1, e1, e0);
        chk("prog_err", e1, 0);
        chk("prog_pending", cfg_if.cfg_pending, 1);
        scan(424, 1'b0);
        chk("prog_mid_eof", eof_cnt, 0);
        chk("prog_mid_sync_first", s_first, 490);
        chk("prog_mid_sync_cnt", s_cnt, 2);
        chk("prog_mid_pending", cfg_if.cfg_pending, 1);
        scan(1, 1'b0);
        chk("prog_end_eof", eof_line, 524);
        chk("prog_end_pending", cfg_if.cfg_pending, 0);
        chk("prog_end_frame", frame_cnt, 3);
        chk("new_vsync_idle", vsync, 0);
        scan(628, 1'b1);
        chk_frame("new", 627, 599, 601, 604, 4, LM_EN, LM200);
        chk("new_frame", frame_cnt, 4);

        // Rejected writes: sync=0, then total=2049
        cfg_write(480, 10, 0, 33, 1'b0, e1, e0);
        chk("rej_sync_err", e1, 1);
        chk("rej_sync_err_off", e0, 0);
        chk("rej_sync_pending", cfg_if.cfg_pending, 0);
        cfg_write(2000, 20, 9, 20, 1'b0, e1, e0);
        chk("rej_total_err", e1, 1);
        chk("rej_total_err_off", e0, 0);
        chk("rej_total_pending", cfg_if.cfg_pending, 0);
        scan(628, 1'b1);
        chk_frame("rej", 627, 599, 601, 604, 4, LM_EN, LM200);

        // Write on the same cycle as the last line's eol
        cfg_write(480, 10, 2, 33, 1'b0, e1, e0);
        chk("sim_a_err", e1, 0);
        scan(627, 1'b1);
        cfg_if.cfg_active = CNT_W'(100); cfg_if.cfg_fp = CNT_W'(0);
        cfg_if.cfg_sync = CNT_W'(3); cfg_if.cfg_bp = CNT_W'(12); cfg_if.cfg_vpol = 1'b1;
        cfg_if.cfg_wr = 1'b1;
        eol = 1'b1;
        @(negedge pix_clk);
        cfg_if.cfg_wr = 1'b0;
        eol = 1'b0;
        chk("sim_eof", eof, 1);
        chk("sim_err", cfg_if.cfg_err, 0);
        chk("sim_pending", cfg_if.cfg_pending, 1);
        chk("sim_vcnt", v_cnt, 0);
        @(negedge pix_clk);
        scan(525, 1'b0);
        chk_frame("sim_old", 524, 479, 490, 491, 2, LM_EN, LM200);
        chk("sim_old_pending", cfg_if.cfg_pending, 0);
        scan(115, 1'b1);
        chk_frame("sim_new", 114, 99, 100, 102, 3, 0, -1);
        chk("sim_new_frame", frame_cnt, 8);

        // Mid-frame reset with a pending config
        cfg_write(600, 1, 4, 23, 1'b1, e1, e0);
        chk("rstm_pending_pre", cfg_if.cfg_pending, 1);
        scan(50, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstm_vcnt", v_cnt, 0);
        chk("rstm_pending", cfg_if.cfg_pending, 0);
        chk("rstm_frame", frame_cnt, 0);
        chk("rstm_flags", {eof, vblank_start, vblank_toggle, eof_toggle, line_match, cfg_if.cfg_err}, 0);
        @(negedge pix_clk);
        rst = 1'b0;
        @(negedge pix_clk);
        scan(525, 1'b0);
        chk_frame("rstm_def", 524, 479, 490, 491, 2, LM_EN, LM200);
        chk("rstm_def_frame", frame_cnt, 1);

        // Compare line beyond the default frame never matches
        cmp_line = CNT_W'(600);
        scan(525, 1'b0);
        chk_frame("cmp600", 524, 479, 490, 491, 2, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vtiming_gen_prog.md
Name: vtiming_gen_prog

Overview:
Next-generation vertical timing generator.
- Advances a line counter on each end-of-line pulse from the horizontal counter and decodes VSYNC, the visible window and frame-boundary pulses.
- Unlike the fixed-timing generation, vertical timings and sync polarity are runtime-programmable. New values go through a shadow register set and are applied only at the frame boundary, so a frame is never torn.
- Also provides a frame counter and CDC toggles for the frame-buffer swap logic in the system clock domain.

Parameters:
CNT_W, 11, width of v_cnt and all timing fields (max total 2^CNT_W lines)
DEF_ACTIVE, 480, reset value of active-line count
DEF_FP, 10, reset value of front-porch lines
DEF_SYNC, 2, reset value of sync lines
DEF_BP, 33, reset value of back-porch lines
DEF_VPOL, 0, reset sync polarity (0 = active-low, 1 = active-high)
FRAME_CNT_W, 16, width of frame_cnt

Ports:
pix_clk  in  1  pixel clock; single clock domain
rst  in  1  asynchronous, active-high reset
eol  in  1  1-cycle pulse at the end of each line
cfg_wr  in  1  1-cycle strobe; capture the cfg_* inputs into the shadow set
cfg_active  in  CNT_W  requested active lines
cfg_fp  in  CNT_W  requested front-porch lines
cfg_sync  in  CNT_W  requested sync lines
cfg_bp  in  CNT_W  requested back-porch lines
cfg_vpol  in  1  requested sync polarity
cmp_line  in  CNT_W  raster-compare line (optional feature)
cfg_pending  out  1  shadow set holds values not yet applied
cfg_err  out  1  1-cycle pulse: the cfg_wr was rejected
v_cnt  out  CNT_W  current line, 0..total-1
vsync  out  1  VSYNC at the active polarity
v_visible  out  1  v_cnt < active
eof  out  1  1-cycle pulse after the last line's eol
vblank_start  out  1  1-cycle pulse after the last visible line's eol
vblank_toggle  out  1  toggles once per vblank_start (CDC)
eof_toggle  out  1  toggles once per eof (CDC)
frame_cnt  out  FRAME_CNT_W  completed frames, wraps modulo 2^FRAME_CNT_W
line_match  out  1  raster-compare pulse (optional feature)

Behaviour:
- Reset (async): active and shadow sets take the DEF_* values.
  - v_cnt=0, frame_cnt=0.
  - cfg_pending, cfg_err, eof, vblank_start, vblank_toggle, eof_toggle, line_match all 0.
- total = active+fp+sync+bp, computed at CNT_W+2 bits (no overflow).
- Counter: on eol, v_cnt wraps to 0 when v_cnt == total-1, else v_cnt+1. No change without eol.
- Decode (combinational from v_cnt and the active set):
  - v_visible = v_cnt < active.
  - insync = active+fp <= v_cnt < active+fp+sync.
  - vsync = insync when vpol=1; vsync = ~insync when vpol=0.
- Pulses (registered, 1-cycle latency after the qualifying eol edge):
  - last_line = eol && v_cnt == total-1 drives eof, eof_toggle flip and frame_cnt+1.
  - last_vis = eol && v_cnt == active-1 drives vblank_start and vblank_toggle flip.
- cfg_wr validation, all checked in the same cycle:
  - Reject if any of active, sync or bp is 0, or if total > 2^CNT_W.
  - fp = 0 is legal.
  - On reject: cfg_err=1 for the next cycle; shadow and cfg_pending are unchanged.
  - On accept: shadow <= cfg_*, cfg_pending <= 1.
- Apply: on a last_line cycle with cfg_pending=1, active <= shadow and cfg_pending <= 0. v_cnt wraps to 0 on the same edge, so the new frame starts entirely under the new timing.
- Simultaneous accepted cfg_wr and apply: the active set takes the old shadow, the shadow takes the new values, cfg_pending stays 1 and the new values apply at the next frame boundary.
- Multiple cfg_wr before a boundary: last accepted write wins.
- The active set never changes mid-frame, so v_cnt is always < total.
- Reset mid-frame: everything returns to the DEF_* values immediately; pending config is discarded.

Optional Feature:
VTIMING_RASTER_CMP_EN
- Defined: line_match=1 one cycle after an eol where v_cnt == cmp_line. cmp_line is sampled live each cycle. If cmp_line >= total, line_match never fires.
- Undefined: line_match is tied to 0, cmp_line is ignored and no compare logic is synthesised. The port list is identical in both builds.

Test Plan:
- Defaults, 2 frames of eol pulses:
  - eof pulses 525 lines apart; vblank_start after the eol at v_cnt=479.
  - vsync low exactly for v_cnt 490-491.
  - frame_cnt=2; eof_toggle back to 0.
- cfg_wr {active 600, fp 1, sync 4, bp 23, vpol 1} at v_cnt=100:
  - Current frame is still 525 lines; cfg_pending=1 until the boundary.
  - Next frame is 628 lines, with vsync high for v_cnt 601-604.
- cfg_wr with sync=0, and separately with total=2049 (CNT_W=11):
  - cfg_err pulses once each time; timing and cfg_pending unchanged.
- cfg_wr on the same cycle as the last_line eol:
  - Old shadow applies and the new values are held (cfg_pending=1).
  - The new values apply one frame later.
- rst asserted mid-frame with a config pending:
  - v_cnt=0, cfg_pending=0, DEF_* timing restored, all pulses and toggles 0.
- VTIMING_RASTER_CMP_EN defined, cmp_line=200:
  - line_match fires once per frame, one cycle after the v_cnt=200 eol.
  - With cmp_line=600 under default timing, it never fires.
